// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared widths, limits, state encoding and field helpers for clock_set_ctrl
package clock_pkg;

    localparam int HRS_W = 5;
    localparam int MS_W  = 6;

    localparam logic [HRS_W-1:0] MAX_HRS = 5'd23;
    localparam logic [MS_W-1:0]  MAX_MS  = 6'd59;

    // Encoding is visible on set_mode, so the values are fixed.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HRS = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    // Increment with wrap at the field maximum.
    function automatic logic [HRS_W-1:0] inc_hrs(input logic [HRS_W-1:0] v);
        return (v == MAX_HRS) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [MS_W-1:0] inc_ms(input logic [MS_W-1:0] v);
        return (v == MAX_MS) ? '0 : v + 1'b1;
    endfunction

    // Out-of-range live values are replaced by 0 on capture.
    function automatic logic [HRS_W-1:0] clamp_hrs(input logic [HRS_W-1:0] v);
        return (v > MAX_HRS) ? '0 : v;
    endfunction

    function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v);
        return (v > MAX_MS) ? '0 : v;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_tick_prescaler.sv
// rtl/clock_set_ctrl_tick_prescaler.sv - one-second tick generator
//
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   en       : advance the count this cycle
//   clr      : force count to 0 and suppress tick (dominates en)
//   tick     : registered one-cycle pulse, once every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set FSM, edit registers and load strobe for the digital clock
//
// Ports:
//   clk, rst                     : rising-edge clock, asynchronous active-high reset
//   mode_btn, inc_btn, cancel_btn: single-cycle button pulses (cancel > mode > inc)
//   cur_hrs, cur_min, cur_sec    : live time from the counter datapath
//   sec_tick                     : one-second count enable to the datapath
//   load_en                      : one-cycle parallel-load strobe on commit
//   load_hrs, load_min, load_sec : edit registers, valid when load_en = 1
//   set_mode                     : current state (0 RUN, 1 HRS, 2 MIN, 3 SEC)
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_btn,
    input  logic             inc_btn,
    input  logic             cancel_btn,
    input  logic [HRS_W-1:0] cur_hrs,
    input  logic [MS_W-1:0]  cur_min,
    input  logic [MS_W-1:0]  cur_sec,
    output logic             sec_tick,
    output logic             load_en,
    output logic [HRS_W-1:0] load_hrs,
    output logic [MS_W-1:0]  load_min,
    output logic [MS_W-1:0]  load_sec,
    output logic [1:0]       set_mode
);

    state_t           state, next_state;
    logic [HRS_W-1:0] edit_hrs, next_hrs;
    logic [MS_W-1:0]  edit_min, next_min;
    logic [MS_W-1:0]  edit_sec, next_sec;
    logic             load_q, next_load;
    logic             stay_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            edit_hrs <= '0;
            edit_min <= '0;
            edit_sec <= '0;
            load_q   <= 1'b0;
        end else begin
            state    <= next_state;
            edit_hrs <= next_hrs;
            edit_min <= next_min;
            edit_sec <= next_sec;
            load_q   <= next_load;
        end
    end

    always_comb begin
        next_state = state;
        next_hrs   = edit_hrs;
        next_min   = edit_min;
        next_sec   = edit_sec;
        next_load  = 1'b0;

        case (state)
            RUN: begin
                // inc/cancel have no meaning here and are dropped.
                if (mode_btn) begin
                    next_state = SET_HRS;
                    next_hrs   = clamp_hrs(cur_hrs);
                    next_min   = clamp_ms(cur_min);
                    next_sec   = clamp_ms(cur_sec);
                end
            end
            SET_HRS: begin
                if (cancel_btn)    next_state = RUN;
                else if (mode_btn) next_state = SET_MIN;
                else if (inc_btn)  next_hrs   = inc_hrs(edit_hrs);
            end
            SET_MIN: begin
                if (cancel_btn)    next_state = RUN;
                else if (mode_btn) next_state = SET_SEC;
                else if (inc_btn)  next_min   = inc_ms(edit_min);
            end
            SET_SEC: begin
                if (cancel_btn) begin
                    next_state = RUN;
                end else if (mode_btn) begin
                    next_state = RUN;
                    next_load  = 1'b1;
                end else if (inc_btn) begin
                    next_sec = inc_ms(edit_sec);
                end
            end
            default: next_state = RUN;
        endcase
    end

    // The prescaler only advances across RUN->RUN edges. Leaving RUN clears
    // it (so no tick lands in the first SET cycle) and entering RUN is also a
    // cleared edge, so the first tick lands exactly TICK_DIV cycles after the
    // return to RUN and can never coincide with load_en.
    assign stay_run = (state == RUN) && (next_state == RUN);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (stay_run),
        .clr (!stay_run),
        .tick(sec_tick)
    );

    assign load_en  = load_q;
    assign load_hrs = edit_hrs;
    assign load_min = edit_min;
    assign load_sec = edit_sec;
    assign set_mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

    localparam int TICK_DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       cancel_btn = 1'b0;
    logic [4:0] cur_hrs = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic       sec_tick;
    logic       load_en;
    logic [4:0] load_hrs;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [1:0] set_mode;

    clock_set_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .cancel_btn(cancel_btn),
        .cur_hrs   (cur_hrs),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .sec_tick  (sec_tick),
        .load_en   (load_en),
        .load_hrs  (load_hrs),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .set_mode  (set_mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode number, edit fields as plain ints, and the
    // number of clock edges spent in RUN since RUN was (re)entered.
    int m_mode = 0;
    int eh = 0, em = 0, es = 0;
    int run_cnt = 0;
    bit exp_tick = 0;
    bit exp_load = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; eh = 0; em = 0; es = 0;
        run_cnt = 0; exp_tick = 0; exp_load = 0;
    endtask

    task automatic model_edge(input bit m, input bit i, input bit c,
                              input int ch, input int cm, input int cs);
        exp_load = 0;
        exp_tick = 0;
        if (m_mode == 0) begin
            if (m) begin
                m_mode  = 1;
                eh      = (ch <= 23) ? ch : 0;
                em      = (cm <= 59) ? cm : 0;
                es      = (cs <= 59) ? cs : 0;
                run_cnt = 0;
            end else begin
                run_cnt++;
                exp_tick = (run_cnt % TICK_DIV) == 0;
            end
        end else begin
            if (c) begin
                m_mode = 0;
                run_cnt = 0;
            end else if (m) begin
                if (m_mode == 3) begin
                    m_mode = 0;
                    exp_load = 1;
                    run_cnt = 0;
                end else begin
                    m_mode++;
                end
            end else if (i) begin
                if (m_mode == 1)      eh = (eh + 1) % 24;
                else if (m_mode == 2) em = (em + 1) % 60;
                else                  es = (es + 1) % 60;
            end
        end
    endtask

    task automatic compare_all();
        check("sec_tick", 32'(sec_tick), 32'(exp_tick));
        check("load_en",  32'(load_en),  32'(exp_load));
        check("set_mode", 32'(set_mode), 32'(m_mode));
        check("load_hrs", 32'(load_hrs), 32'(eh));
        check("load_min", 32'(load_min), 32'(em));
        check("load_sec", 32'(load_sec), 32'(es));
    endtask

    // One clock: drive pulses, clock, update model, compare, clear pulses.
    task automatic step(input bit m, input bit i, input bit c);
        mode_btn = m; inc_btn = i; cancel_btn = c;
        @(posedge clk);
        #1;
        model_edge(m, i, c, int'(cur_hrs), int'(cur_min), int'(cur_sec));
        compare_all();
        mode_btn = 0; inc_btn = 0; cancel_btn = 0;
    endtask

    task automatic steps(input int n, input bit m, input bit i);
        for (int k = 0; k < n; k++) step(m, i, 0);
    endtask

    // Idle until the next sec_tick; report its distance in cycles.
    task automatic tick_distance(input string name, input int required);
        int found = -1;
        for (int k = 1; k <= 3 * TICK_DIV; k++) begin
            step(0, 0, 0);
            if (sec_tick === 1'b1) begin
                found = k;
                break;
            end
        end
        check(name, 32'(found), 32'(required));
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hrs = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    initial begin
        int first_tick, n_ticks, last_tick;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 0;

        // 1: free-running ticks at 10, 20, 30
        first_tick = -1; n_ticks = 0; last_tick = -1;
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 0);
            if (sec_tick === 1'b1) begin
                if (first_tick < 0) first_tick = k;
                last_tick = k;
                n_ticks++;
            end
        end
        check("t1_first_tick", 32'(first_tick), 32'd10);
        check("t1_last_tick", 32'(last_tick), 32'd30);
        check("t1_tick_count", 32'(n_ticks), 32'd3);

        // 2: 12:34:56 edited to 15:00:01
        set_cur(12, 34, 56);
        step(1, 0, 0);
        check("t2_mode_hrs", 32'(set_mode), 32'd1);
        steps(3, 0, 1);
        step(1, 0, 0);
        check("t2_mode_min", 32'(set_mode), 32'd2);
        steps(26, 0, 1);
        step(1, 0, 0);
        check("t2_mode_sec", 32'(set_mode), 32'd3);
        steps(5, 0, 1);
        step(1, 0, 0);
        check("t2_mode_run", 32'(set_mode), 32'd0);
        check("t2_load_en", 32'(load_en), 32'd1);
        check("t2_load_hrs", 32'(load_hrs), 32'd15);
        check("t2_load_min", 32'(load_min), 32'd0);
        check("t2_load_sec", 32'(load_sec), 32'd1);
        tick_distance("t2_tick_after_load", 10);

        // 3: wrap of every field
        set_cur(23, 59, 59);
        step(1, 0, 0); step(0, 1, 0);
        step(1, 0, 0); step(0, 1, 0);
        step(1, 0, 0); step(0, 1, 0);
        step(1, 0, 0);
        check("t3_load_en", 32'(load_en), 32'd1);
        check("t3_load_time", {load_hrs, load_min, load_sec}, 32'd0);

        // 4: cancel paths
        set_cur(5, 6, 7);
        step(1, 0, 0);
        steps(2, 0, 1);
        check("t4_hrs_edit", 32'(load_hrs), 32'd7);
        step(0, 0, 1);
        check("t4_cancel_mode", 32'(set_mode), 32'd0);
        check("t4_cancel_load", 32'(load_en), 32'd0);
        tick_distance("t4_tick_after_cancel", 10);
        step(1, 0, 0); step(1, 0, 0);
        check("t4_in_min", 32'(set_mode), 32'd2);
        step(1, 0, 1);
        check("t4_cancel_wins", 32'(set_mode), 32'd0);
        check("t4_cancel_wins_load", 32'(load_en), 32'd0);
        steps(4, 0, 0);

        // 5: async reset mid-edit
        step(1, 0, 0); step(1, 0, 0); step(0, 1, 0);
        #3;
        rst = 1;
        #1;
        model_reset();
        compare_all();
        check("t5_async_mode", 32'(set_mode), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        tick_distance("t5_tick_after_reset", 10);
        tick_distance("t5_tick_period", 10);

        // 6: clamp on capture; mode beats inc
        set_cur(30, 61, 45);
        step(1, 0, 0);
        check("t6_clamp_hrs", 32'(load_hrs), 32'd0);
        check("t6_clamp_min", 32'(load_min), 32'd0);
        check("t6_keep_sec", 32'(load_sec), 32'd45);
        step(1, 1, 0);
        check("t6_mode_wins", 32'(set_mode), 32'd2);
        check("t6_hrs_unchanged", 32'(load_hrs), 32'd0);
        step(0, 0, 1);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            set_cur(int'($urandom % 32), int'($urandom % 64), int'($urandom % 64));
            step(($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 20) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Controller that sequences the digital_clock counter datapath.
- Generates the one-second count-enable pulse from the system clock.
- Runs a user time-set FSM driven by single-cycle button pulses (mode, inc, cancel).
- Issues a one-cycle parallel load of hrs/min/sec into the counter when an edit is committed.

Parameters:
TICK_DIV, 1000, clk cycles per sec_tick; legal range >= 2.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
mode_btn  in  1  single-cycle pulse; enter set mode or advance the field being edited.
inc_btn  in  1  single-cycle pulse; increment the field being edited.
cancel_btn  in  1  single-cycle pulse; abandon the edit.
cur_hrs  in  5  live hours from the counter datapath (0..23).
cur_min  in  6  live minutes from the counter datapath (0..59).
cur_sec  in  6  live seconds from the counter datapath (0..59).
sec_tick  out  1  count enable to the datapath; one-cycle pulse.
load_en  out  1  one-cycle strobe; datapath loads load_* on this cycle.
load_hrs  out  5  edit register, hours.
load_min  out  6  edit register, minutes.
load_sec  out  6  edit register, seconds.
set_mode  out  2  0 = RUN, 1 = SET_HRS, 2 = SET_MIN, 3 = SET_SEC.

Behaviour:
- Reset (async assert, any state):
  - state = RUN; prescaler = 0.
  - Edit registers = 0.
  - sec_tick = 0, load_en = 0, set_mode = 0.
  - Any edit in progress is discarded; no load_en is issued.
- All outputs are registered; set_mode equals the encoding of the state register.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while state = RUN.
  - sec_tick = 1 for exactly the cycle after the count reaches TICK_DIV-1; the count wraps to 0. Period is exactly TICK_DIV cycles.
  - In any SET state: prescaler is held at 0 and sec_tick = 0.
- FSM transitions:
  - RUN + mode_btn -> SET_HRS.
    - Capture cur_hrs/min/sec into the edit registers.
    - Any out-of-range captured value (hrs > 23, min or sec > 59) is clamped to 0.
  - SET_HRS + inc_btn: edit_hrs = (edit_hrs == 23) ? 0 : edit_hrs + 1.
  - SET_MIN + inc_btn: edit_min wraps 59 -> 0.
  - SET_SEC + inc_btn: edit_sec wraps 59 -> 0.
  - SET_HRS + mode_btn -> SET_MIN; SET_MIN + mode_btn -> SET_SEC.
  - SET_SEC + mode_btn -> RUN (commit).
    - load_en = 1 for the first RUN cycle only; load_* hold the edit values.
    - Prescaler restarts from 0, so the first sec_tick follows TICK_DIV cycles after load_en.
  - Any SET state + cancel_btn -> RUN, no load_en; prescaler restarts from 0.
- Priority when pulses coincide in the same cycle: cancel_btn > mode_btn > inc_btn.
  - The losing pulses are ignored; they are not queued.
- Button pulses arriving in a state where they have no meaning are ignored (inc_btn and cancel_btn in RUN).
- load_* outputs are driven from the edit registers at all times. The datapath must sample them only when load_en = 1.
- load_en and sec_tick are never asserted in the same cycle.
- Input pulses are assumed already debounced and synchronised upstream; this block does no debouncing.

Decomposition:
- Package clock_pkg:
  - Constants: HRS_W = 5, MS_W = 6, MAX_HRS = 23, MAX_MS = 59.
  - State typedef (RUN, SET_HRS, SET_MIN, SET_SEC) with encoding 0..3.
- Sub-module tick_prescaler:
  - Parameter TICK_DIV.
  - Ports: clk, rst, en, clr, tick.
  - Counter width = $clog2(TICK_DIV).
- The FSM, edit registers and wrap logic stay in clock_set_ctrl.

Test Plan:
1. TICK_DIV = 10; release rst; hold RUN -> sec_tick pulses at cycles 10, 20, 30 after reset release; set_mode = 0; load_en never asserted.
2. cur = 12:34:56; mode, inc×3, mode, inc×26, mode, inc×5, mode -> set_mode steps 1, 2, 3, 0; single load_en with load = 15:00:01; next sec_tick exactly 10 cycles after load_en.
3. Wrap: cur = 23:59:59; mode, inc, mode, inc, mode, inc, mode -> load = 00:00:00.
4. Enter set mode, inc×2 in SET_HRS, then cancel_btn -> set_mode = 0, no load_en, first sec_tick 10 cycles after cancel; mode and cancel in the same cycle in SET_MIN -> cancel wins.
5. Assert rst mid-edit in SET_MIN -> all outputs 0 immediately (async), no load_en after release, ticks resume at 10-cycle period.
6. cur_hrs = 30, cur_min = 61 at entry -> captured as 0; mode and inc in the same cycle in SET_HRS -> move to SET_MIN, edit_hrs unchanged.
